// File: rtl/count_bank_pkg.sv
// rtl/count_bank_pkg.sv - shared constants and helpers for the counter bank
package count_bank_pkg;

    localparam logic DIR_UP    = 1'b1;
    localparam logic DIR_DOWN  = 1'b0;
    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    // All-ones value of a width-bit counter; 32-bit modulo keeps width=32 correct
    function automatic logic [31:0] max_val(input int unsigned width);
        return (32'd1 << width) - 32'd1;
    endfunction

endpackage

// File: rtl/count_chan.sv
// rtl/count_chan.sv - one up/down counter channel with load, wrap/saturate and terminal count
module count_chan
    import count_bank_pkg::*;
#(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             tick,
    input  logic             en,
    input  logic             dir,
    input  logic             sat,
    input  logic             we,
    input  logic [WIDTH-1:0] wq,
    output logic [WIDTH-1:0] q,
    output logic             tc
);

    localparam logic [WIDTH-1:0] MAXV = WIDTH'(max_val(WIDTH));

    logic at_bound;

    assign at_bound = (dir == DIR_UP) ? (q == MAXV) : (q == '0);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            q  <= '0;
            tc <= 1'b0;
        end else if (we) begin
            q  <= wq;
            tc <= 1'b0;
        end else if (en && tick) begin
            if (at_bound) begin
                // Saturating channels re-flag tc on every step attempted at the boundary
                tc <= 1'b1;
                if (sat == MODE_WRAP)
                    q <= (dir == DIR_UP) ? '0 : MAXV;
            end else begin
                tc <= 1'b0;
                q  <= (dir == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
            end
        end else begin
            tc <= 1'b0;
        end
    end

endmodule

// File: rtl/count_bank.sv
// rtl/count_bank.sv - bank of independent counters sharing one free-running prescaler
module count_bank
    import count_bank_pkg::*;
#(
    parameter int WIDTH    = 6,
    parameter int CHANNELS = 3,
    parameter int PRESCALE = 1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       dir,
    input  logic [CHANNELS-1:0]       sat,
    input  logic [CHANNELS-1:0]       we,
    input  logic [CHANNELS*WIDTH-1:0] wq,
    output logic [CHANNELS*WIDTH-1:0] q,
    output logic [CHANNELS-1:0]       tc,
    output logic [CHANNELS-1:0]       zero
);

    localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic tick;

    generate
        if (PRESCALE == 1) begin : g_nopre
            assign tick = 1'b1;
        end else begin : g_pre
            logic [PW-1:0] pcnt;
            assign tick = (pcnt == PW'(PRESCALE - 1));
            always_ff @(posedge clk or negedge reset) begin
                if (!reset)
                    pcnt <= '0;
                else
                    pcnt <= tick ? '0 : pcnt + PW'(1);
            end
        end
    endgenerate

    generate
        for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
            count_chan #(.WIDTH(WIDTH)) u_chan (
                .clk   (clk),
                .reset (reset),
                .tick  (tick),
                .en    (en[k]),
                .dir   (dir[k]),
                .sat   (sat[k]),
                .we    (we[k]),
                .wq    (wq[k*WIDTH +: WIDTH]),
                .q     (q[k*WIDTH +: WIDTH]),
                .tc    (tc[k])
            );
            assign zero[k] = (q[k*WIDTH +: WIDTH] == '0);
        end
    endgenerate

endmodule

// File: tb/tb_count_bank.sv
// tb/tb_count_bank.sv - directed self-checking bench for count_bank
module tb_count_bank;

    localparam int W = 6;
    localparam int C = 3;

    logic           clk = 1'b0;
    logic           reset;
    logic [C-1:0]   en, dir, sat, we;
    logic [C*W-1:0] wq;
    logic [C*W-1:0] q;
    logic [C-1:0]   tc, zero;

    logic           r1;
    logic [C-1:0]   en1, dir1, sat1, we1;
    logic [C*W-1:0] wq1;
    logic [C*W-1:0] q1;
    logic [C-1:0]   tc1, zero1;

    int checks = 0;
    int errors = 0;

    count_bank #(.WIDTH(W), .CHANNELS(C), .PRESCALE(1)) u_dut (
        .clk(clk), .reset(reset), .en(en), .dir(dir), .sat(sat), .we(we),
        .wq(wq), .q(q), .tc(tc), .zero(zero)
    );

    count_bank #(.WIDTH(W), .CHANNELS(C), .PRESCALE(4)) u_dut4 (
        .clk(clk), .reset(r1), .en(en1), .dir(dir1), .sat(sat1), .we(we1),
        .wq(wq1), .q(q1), .tc(tc1), .zero(zero1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic edge1();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b0; en = '0; dir = '0; sat = '0; we = '0; wq = '0;
        r1 = 1'b0; en1 = '0; dir1 = '0; sat1 = '0; we1 = '0; wq1 = '0;

        #3;
        chk("reset_q", 32'(q), 0);
        chk("reset_tc", 32'(tc), 0);
        chk("reset_zero", 32'(zero), 3'b111);
        edge1();
        chk("reset_hold_q", 32'(q), 0);

        reset = 1'b1; en[2] = 1'b1; dir[2] = 1'b0; sat[2] = 1'b0;
        edge1();
        chk("wrap_first_q2", 32'(q[2*W +: W]), 63);
        chk("wrap_first_tc", 32'(tc), 3'b100);
        edge1();
        chk("down_q2_62", 32'(q[2*W +: W]), 62);
        chk("down_tc_clear", 32'(tc), 0);
        for (int i = 0; i < 62; i++) edge1();
        chk("down_q2_0", 32'(q[2*W +: W]), 0);
        chk("down_zero", 32'(zero), 3'b111);
        chk("down_tc_at0", 32'(tc), 0);
        edge1();
        chk("wrap_again_q2", 32'(q[2*W +: W]), 63);
        chk("wrap_again_tc", 32'(tc), 3'b100);
        chk("wrap_again_zero", 32'(zero), 3'b011);
        en[2] = 1'b0;

        we[0] = 1'b1; wq[0 +: W] = 6'd5; en[0] = 1'b1; dir[0] = 1'b1;
        edge1();
        chk("load_q0", 32'(q[0 +: W]), 5);
        chk("load_tc", 32'(tc), 0);
        chk("load_q1_kept", 32'(q[W +: W]), 0);
        chk("load_q2_kept", 32'(q[2*W +: W]), 63);
        we[0] = 1'b0; en[0] = 1'b0;

        we[1] = 1'b1; wq[W +: W] = 6'd62;
        edge1();
        chk("sat_load_q1", 32'(q[W +: W]), 62);
        we[1] = 1'b0; en[1] = 1'b1; dir[1] = 1'b1; sat[1] = 1'b1;
        edge1();
        chk("sat_step_q1", 32'(q[W +: W]), 63);
        chk("sat_step_tc", 32'(tc), 0);
        edge1();
        chk("sat_hold_q1", 32'(q[W +: W]), 63);
        chk("sat_hold_tc", 32'(tc), 3'b010);
        edge1();
        chk("sat_hold2_q1", 32'(q[W +: W]), 63);
        chk("sat_hold2_tc", 32'(tc), 3'b010);
        we[1] = 1'b1; wq[W +: W] = 6'd63;
        edge1();
        chk("load_wins_q1", 32'(q[W +: W]), 63);
        chk("load_wins_tc", 32'(tc), 0);
        we[1] = 1'b0; en[1] = 1'b0;

        we[0] = 1'b1; wq[0 +: W] = 6'd63;
        edge1();
        we[0] = 1'b0; en[0] = 1'b1; dir[0] = 1'b1; sat[0] = 1'b0;
        edge1();
        chk("upwrap_q0", 32'(q[0 +: W]), 0);
        chk("upwrap_tc", 32'(tc), 3'b001);
        chk("upwrap_zero", 32'(zero[0]), 1);
        en[0] = 1'b0;

        we[2] = 1'b1; wq[2*W +: W] = 6'd40;
        edge1();
        we[2] = 1'b0; en[2] = 1'b1; dir[2] = 1'b1; sat[2] = 1'b0;
        edge1();
        chk("pre_reset_q2", 32'(q[2*W +: W]), 41);
        #2;
        reset = 1'b0;
        #1;
        chk("async_q", 32'(q), 0);
        chk("async_tc", 32'(tc), 0);
        chk("async_zero", 32'(zero), 3'b111);
        #1;
        reset = 1'b1;
        edge1();
        chk("restart_q2", 32'(q[2*W +: W]), 1);
        en = '0;

        r1 = 1'b1; we1[0] = 1'b1; wq1[0 +: W] = 6'd10;
        edge1();
        chk("pre_load_q0", 32'(q1[0 +: W]), 10);
        we1[0] = 1'b0; en1[0] = 1'b1; dir1[0] = 1'b0;
        edge1();
        chk("pre_e2_q0", 32'(q1[0 +: W]), 10);
        edge1();
        chk("pre_e3_q0", 32'(q1[0 +: W]), 10);
        edge1();
        chk("pre_e4_q0", 32'(q1[0 +: W]), 9);
        edge1(); edge1(); edge1();
        chk("pre_e7_q0", 32'(q1[0 +: W]), 9);
        edge1();
        chk("pre_e8_q0", 32'(q1[0 +: W]), 8);
        we1[0] = 1'b1; wq1[0 +: W] = 6'd20;
        edge1();
        chk("pre_midload_q0", 32'(q1[0 +: W]), 20);
        we1[0] = 1'b0;
        edge1(); edge1();
        chk("pre_e11_q0", 32'(q1[0 +: W]), 20);
        edge1();
        chk("pre_e12_q0", 32'(q1[0 +: W]), 19);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
